// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Registered output stage behind the combinational logical unit. Captures
//   the N-bit result and its 2-bit op code, derives zero/negative flags at
//   capture time and hands entries downstream over valid/ready. A main
//   register plus one skid register give full throughput while keeping
//   in_ready a pure register output, so downstream back-pressure never
//   reaches the logical unit combinationally.
//
//   Optional feature macro: ALU_PARITY_EN
//     When defined, each entry also stores ^in_result and the out_parity
//     port exists with the same timing as out_zero.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   in_valid    upstream result/op valid this cycle
//   in_ready    stage can accept (registered)
//   in_result   N-bit result from logical unit
//   in_op       op code (00 AND, 01 OR, 10 XOR, 11 NOR), carried unchanged
//   out_valid   out_* hold a valid entry
//   out_ready   downstream accepts this cycle
//   out_result  buffered result
//   out_op      buffered op code
//   out_zero    buffered result == 0
//   out_neg     buffered result MSB
//   xfer_count  completed output handshakes, wrapping
//   out_parity  (ALU_PARITY_EN only) XOR-reduce of buffered result
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_result,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_result,
  output logic [1:0]    out_op,
  output logic          out_zero,
  output logic          out_neg,
  output logic [CW-1:0] xfer_count
`ifdef ALU_PARITY_EN
  ,
  output logic          out_parity
`endif
);

  typedef struct packed {
    logic [N-1:0] result;
    logic [1:0]   op;
    logic         zero;
    logic         neg;
`ifdef ALU_PARITY_EN
    logic         parity;
`endif
  } entry_t;

  entry_t        r_main, r_skid, w_in_entry;
  logic          r_main_valid, r_skid_valid, r_in_ready;
  logic [CW-1:0] r_xfer_cnt;
  logic          w_accept, w_xfer;

  // Flags are derived once, at capture, and travel with the entry.
  always_comb begin
    w_in_entry        = '0;
    w_in_entry.result = in_result;
    w_in_entry.op     = in_op;
    w_in_entry.zero   = (in_result == {N{1'b0}});
    w_in_entry.neg    = in_result[N-1];
`ifdef ALU_PARITY_EN
    w_in_entry.parity = ^in_result;
`endif
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_xfer   = r_main_valid & out_ready;

  // State is {r_main_valid, r_skid_valid}: EMPTY 00, ONE 10, FULL 11.
  // r_in_ready is kept equal to ~r_skid_valid but lives in its own flop so
  // the port is a clean register output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_xfer_cnt   <= '0;
    end else begin
      if (w_xfer) r_xfer_cnt <= r_xfer_cnt + 1'b1;

      if (w_xfer || !r_main_valid) begin
        // Main is free this edge: skid has priority to keep FIFO order.
        // (Accept cannot coincide with a valid skid since in_ready is low.)
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_main_valid <= 1'b1;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else if (w_accept) begin
          r_main       <= w_in_entry;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        // Main is stalled: park the new entry in the skid and stop input.
        r_skid       <= w_in_entry;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_main_valid;
  assign out_result = r_main.result;
  assign out_op     = r_main.op;
  assign out_zero   = r_main.zero;
  assign out_neg    = r_main.neg;
  assign xfer_count = r_xfer_cnt;
`ifdef ALU_PARITY_EN
  assign out_parity = r_main.parity;
`endif

endmodule
